// File: rtl/serial_work_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_work_rx_pkg
// Brief   : Shared constants and receiver state encoding for serial_work_rx.
// Revision: 1.0
// ============================================================================
package serial_work_rx_pkg;

    localparam int WORK_BYTES = 44;
    localparam int MIDSTATE_W = 256;
    localparam int DATA_W     = 96;
    localparam int SHIFT_W    = MIDSTATE_W + DATA_W;
    localparam int COUNT_W    = 6;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_byte
// Brief   : 8N1 UART byte receiver with input synchroniser and framing check.
// Revision: 1.0
// ============================================================================
module uart_rx_byte
    import serial_work_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] c_BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] c_HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state;
    logic [TW-1:0]   r_timer;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_wait_high;
    logic            r_byte_valid;
    logic            r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RX_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_wait_high  <= 1'b0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_timer   <= '0;
                    r_bit_idx <= '0;
                    if (!r_sync2) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    // A line that is high again at mid start bit was a glitch.
                    if (r_timer == c_HALF_LAST) begin
                        r_timer <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_timer == c_BIT_LAST) begin
                        r_timer            <= '0;
                        r_shift[r_bit_idx] <= r_sync2;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    // After a framing error, hold here until the line idles high.
                    if (r_wait_high) begin
                        if (r_sync2) begin
                            r_wait_high <= 1'b0;
                            r_state     <= RX_IDLE;
                        end
                    end else if (r_timer == c_BIT_LAST) begin
                        r_timer <= '0;
                        if (r_sync2) begin
                            r_byte_valid <= 1'b1;
                            r_state      <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_wait_high <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_byte_valid;
    assign o_frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/serial_work_rx.sv
`default_nettype none
// ============================================================================
// Module  : serial_work_rx
// Brief   : Assembles 44 UART bytes into a SHA-256 midstate + header tail.
// Revision: 1.0
// ============================================================================
module serial_work_rx
    import serial_work_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 5000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RxD,
    output logic [MIDSTATE_W-1:0] midstate,
    output logic [DATA_W-1:0]     data,
    output logic                  new_work,
    output logic                  rx_error
);

    localparam int IW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IW-1:0]      c_IDLE_LAST  = IW'(TIMEOUT_CLKS - 1);
    localparam logic [COUNT_W-1:0] c_COUNT_LAST = COUNT_W'(WORK_BYTES - 1);

    logic [7:0]            w_byte;
    logic                  w_byte_valid;
    logic                  w_frame_err;
    logic                  w_last_byte;
    logic                  w_timeout;
    logic [SHIFT_W-1:0]    w_shift_next;

    // Holds the prior 43 bytes; the full 352-bit window is w_shift_next.
    logic [SHIFT_W-9:0]    r_shift;
    logic [COUNT_W-1:0]    r_count;
    logic [IW-1:0]         r_idle;
    logic [MIDSTATE_W-1:0] r_midstate;
    logic [DATA_W-1:0]     r_data;
    logic                  r_new_work;
    logic                  r_rx_error;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx_byte (
        .clk          (clk),
        .rst          (rst),
        .i_rxd        (RxD),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    assign w_shift_next = {r_shift, w_byte};
    assign w_last_byte  = (r_count == c_COUNT_LAST);
    assign w_timeout    = (r_count != '0) && (r_idle == c_IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_count    <= '0;
            r_idle     <= '0;
            r_midstate <= '0;
            r_data     <= '0;
            r_new_work <= 1'b0;
            r_rx_error <= 1'b0;
        end else begin
            r_new_work <= 1'b0;
            // Coincident framing error and timeout merge into a single pulse.
            r_rx_error <= w_frame_err | (w_timeout & ~w_byte_valid);
            if (w_byte_valid) begin
                r_shift <= w_shift_next[SHIFT_W-9:0];
                r_idle  <= '0;
                if (w_last_byte) begin
                    r_midstate <= w_shift_next[SHIFT_W-1:DATA_W];
                    r_data     <= w_shift_next[DATA_W-1:0];
                    r_new_work <= 1'b1;
                    r_count    <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_frame_err || w_timeout) begin
                r_count <= '0;
                r_idle  <= '0;
            end else if (r_count != '0) begin
                r_idle <= r_idle + 1'b1;
            end else begin
                r_idle <= '0;
            end
        end
    end

    assign midstate = r_midstate;
    assign data     = r_data;
    assign new_work = r_new_work;
    assign rx_error = r_rx_error;

endmodule
`default_nettype wire

// File: tb/tb_serial_work_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_work_rx
// Brief   : Randomised scoreboard bench for serial_work_rx.
// Revision: 1.0
// ============================================================================
module tb_serial_work_rx;
    import serial_work_rx_pkg::*;

    localparam int CPB = 8;
    localparam int TMO = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         RxD = 1'b1;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic         new_work;
    logic         rx_error;

    serial_work_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .RxD      (RxD),
        .midstate (midstate),
        .data     (data),
        .new_work (new_work),
        .rx_error (rx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0]   pkt_q[$];
    logic [255:0] exp_mid_q[$];
    logic [95:0]  exp_data_q[$];
    int exp_err      = 0;
    int exp_nw_total = 0;
    int exp_err_total = 0;
    int nw_seen  = 0;
    int err_seen = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: a packet is 44 bytes; first 32 form the midstate MSB-first, last 12 the data.
    function automatic void model_good_byte(input logic [7:0] b);
        logic [255:0] m;
        logic [95:0]  d;
        pkt_q.push_back(b);
        if (pkt_q.size() == WORK_BYTES) begin
            for (int i = 0; i < 32; i++) m[255-8*i -: 8] = pkt_q[i];
            for (int i = 0; i < 12; i++) d[95-8*i -: 8] = pkt_q[32+i];
            exp_mid_q.push_back(m);
            exp_data_q.push_back(d);
            exp_nw_total++;
            pkt_q.delete();
        end
    endfunction

    function automatic void model_error();
        pkt_q.delete();
        exp_err++;
        exp_err_total++;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic uart_byte(input logic [7:0] b, input logic stop);
        RxD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            tick(CPB);
        end
        RxD = stop;
        tick(CPB);
        RxD = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input int max_gap);
        model_good_byte(b);
        uart_byte(b, 1'b1);
        if (max_gap > 0) tick($urandom_range(0, max_gap));
    endtask

    task automatic send_counting_packet();
        for (int i = 0; i < WORK_BYTES; i++) send_good(8'(i), 12);
    endtask

    task automatic send_random_packet(input int max_gap);
        for (int i = 0; i < WORK_BYTES; i++) send_good(8'($urandom), max_gap);
    endtask

    // Monitor: pops expected work/errors whenever the DUT pulses an output.
    initial begin
        forever begin
            @(negedge clk);
            if (new_work) begin
                nw_seen++;
                if (exp_mid_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_new_work actual=1 required=0 midstate=%h", midstate);
                end else begin
                    check("midstate", midstate, exp_mid_q.pop_front());
                    check("data", {160'd0, data}, {160'd0, exp_data_q.pop_front()});
                end
            end
            if (rx_error) begin
                err_seen++;
                checks++;
                if (exp_err == 0) begin
                    errors++;
                    $display("FAIL unexpected_rx_error actual=1 required=0");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        RxD = 1'b1;
        rst = 1'b1;
        tick(5);
        check("reset_midstate", midstate, 256'd0);
        check("reset_data", {160'd0, data}, 256'd0);
        check("reset_new_work", {255'd0, new_work}, 256'd0);
        check("reset_rx_error", {255'd0, rx_error}, 256'd0);
        rst = 1'b0;
        tick(4 * CPB);

        // Counting packet 0x00..0x2B.
        send_counting_packet();
        tick(2 * CPB);

        // Partial packet abandoned by timeout, then a full one.
        for (int i = 0; i < 20; i++) send_good(8'($urandom), 12);
        model_error();
        tick(300);
        send_counting_packet();
        tick(2 * CPB);

        // Framing error on byte 10, then a clean random packet.
        for (int i = 0; i < 9; i++) send_good(8'($urandom), 12);
        model_error();
        uart_byte(8'($urandom), 1'b0);
        tick(2 * CPB);
        send_random_packet(12);
        tick(2 * CPB);

        // Short low glitch must not start a byte.
        RxD = 1'b0;
        tick(3);
        RxD = 1'b1;
        tick(3 * CPB);
        send_random_packet(12);
        tick(2 * CPB);

        // Reset during byte 30.
        for (int i = 0; i < 29; i++) send_good(8'($urandom), 12);
        RxD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            RxD = 1'($urandom);
            tick(CPB);
        end
        rst = 1'b1;
        pkt_q.delete();
        tick(2);
        RxD = 1'b1;
        check("midreset_midstate", midstate, 256'd0);
        check("midreset_data", {160'd0, data}, 256'd0);
        rst = 1'b0;
        tick(2 * CPB);
        send_random_packet(12);
        tick(2 * CPB);

        // Two back-to-back packets with no gaps.
        send_random_packet(0);
        send_random_packet(0);

        wait_cnt = 0;
        while ((exp_mid_q.size() != 0 || exp_err != 0) && wait_cnt < 2000) begin
            tick(1);
            wait_cnt++;
        end
        tick(4 * CPB);
        check("work_queue_drained", 256'(exp_mid_q.size()), 256'd0);
        check("rx_error_pending", 256'(exp_err), 256'd0);
        check("new_work_count", 256'(nw_seen), 256'(exp_nw_total));
        check("rx_error_count", 256'(err_seen), 256'(exp_err_total));
        check("final_rx_error_low", {255'd0, rx_error}, 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
